wb_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the shared bus driven by the CPU core.
- Master 0 is the CPU instruction/operand fetch path. Master 1 is a second requester (data store or DMA).
- Grants the single slave-side bus (W_ADDR, W_DAT_O, W_DAT_I, W_ACK) to one master at a time, using round-robin.
- Watches every transfer with a no-ACK timeout, so a dead slave cannot stall the CPU state machine.

---
 rtl/wb_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_wb_bus_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: two-master round-robin arbiter onto one Wishbone-style slave bus, with no-ACK timeout.
// Ports: clk, W_RST (async active-low reset)
//        M0_*/M1_*  master side: REQ/WE/ADDR/DAT in; RDAT/ACK/ERR out (ACK/ERR are one-cycle pulses)
//        W_*        slave side: CYC/STB/WE/ADDR/DAT_O out; DAT_I/ACK in
//        GNT        index of the master that owns (or last owned) the slave bus
module wb_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          W_RST,
    input  logic          M0_REQ,
    input  logic          M0_WE,
    input  logic [AW-1:0] M0_ADDR,
    input  logic [DW-1:0] M0_DAT,
    output logic [DW-1:0] M0_RDAT,
    output logic          M0_ACK,
    output logic          M0_ERR,
    input  logic          M1_REQ,
    input  logic          M1_WE,
    input  logic [AW-1:0] M1_ADDR,
    input  logic [DW-1:0] M1_DAT,
    output logic [DW-1:0] M1_RDAT,
    output logic          M1_ACK,
    output logic          M1_ERR,
    output logic          W_CYC,
    output logic          W_STB,
    output logic          W_WE,
    output logic [AW-1:0] W_ADDR,
    output logic [DW-1:0] W_DAT_O,
    input  logic [DW-1:0] W_DAT_I,
    input  logic          W_ACK,
    output logic          GNT
);
    localparam int CW = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t        state_q, state_d;
    logic          cyc_q, cyc_d, we_q, we_d, gnt_q, gnt_d, last_q, last_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] dat_q, dat_d, rdat0_q, rdat0_d, rdat1_q, rdat1_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ack0_q, ack0_d, err0_q, err0_d, ack1_q, ack1_d, err1_q, err1_d;
    logic          pick, req_g, expire;

    // Under contention the master that did not win last time goes next.
    assign pick   = (M0_REQ & M1_REQ) ? ~last_q : M1_REQ;
    assign req_g  = gnt_q ? M1_REQ : M0_REQ;
    assign expire = (TIMEOUT != 0) && (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        addr_d  = addr_q;
        dat_d   = dat_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        rdat0_d = rdat0_q;
        rdat1_d = rdat1_q;
        ack0_d  = 1'b0;
        err0_d  = 1'b0;
        ack1_d  = 1'b0;
        err1_d  = 1'b0;
        case (state_q)
            IDLE: if (M0_REQ | M1_REQ) begin
                state_d = XFER;
                cyc_d   = 1'b1;
                we_d    = pick ? M1_WE : M0_WE;
                addr_d  = pick ? M1_ADDR : M0_ADDR;
                dat_d   = pick ? M1_DAT : M0_DAT;
                gnt_d   = pick;
                last_d  = pick;
                cnt_d   = '0;
            end
            XFER: if (W_ACK) begin
                // A completed slave cycle is always reported, even if the master gave up meanwhile.
                state_d = DONE;
                cyc_d   = 1'b0;
                rdat0_d = gnt_q ? rdat0_q : W_DAT_I;
                rdat1_d = gnt_q ? W_DAT_I : rdat1_q;
                ack0_d  = ~gnt_q;
                ack1_d  = gnt_q;
            end else if (!req_g) begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end else if (expire) begin
                state_d = DONE;
                cyc_d   = 1'b0;
                err0_d  = ~gnt_q;
                err1_d  = gnt_q;
            end else begin
                cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge W_RST) begin
        if (!W_RST) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            dat_q   <= '0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            rdat0_q <= '0;
            rdat1_q <= '0;
            ack0_q  <= 1'b0;
            err0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            dat_q   <= dat_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rdat0_q <= rdat0_d;
            rdat1_q <= rdat1_d;
            ack0_q  <= ack0_d;
            err0_q  <= err0_d;
            ack1_q  <= ack1_d;
            err1_q  <= err1_d;
        end
    end

    assign W_CYC   = cyc_q;
    assign W_STB   = cyc_q;
    assign W_WE    = we_q;
    assign W_ADDR  = addr_q;
    assign W_DAT_O = dat_q;
    assign GNT     = gnt_q;
    assign M0_RDAT = rdat0_q;
    assign M1_RDAT = rdat1_q;
    assign M0_ACK  = ack0_q;
    assign M0_ERR  = err0_q;
    assign M1_ACK  = ack1_q;
    assign M1_ERR  = err1_q;
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb_wb_bus_arbiter: randomized scoreboard bench for wb_bus_arbiter against a transaction-level model.
module tb_wb_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          W_RST;
    logic          M0_REQ, M0_WE, M1_REQ, M1_WE;
    logic [AW-1:0] M0_ADDR, M1_ADDR;
    logic [DW-1:0] M0_DAT, M1_DAT;
    logic [DW-1:0] M0_RDAT, M1_RDAT;
    logic          M0_ACK, M0_ERR, M1_ACK, M1_ERR;
    logic          W_CYC, W_STB, W_WE, W_ACK, GNT;
    logic [AW-1:0] W_ADDR;
    logic [DW-1:0] W_DAT_O, W_DAT_I;

    always #5 clk = ~clk;

    wb_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .W_RST(W_RST),
        .M0_REQ(M0_REQ), .M0_WE(M0_WE), .M0_ADDR(M0_ADDR), .M0_DAT(M0_DAT),
        .M0_RDAT(M0_RDAT), .M0_ACK(M0_ACK), .M0_ERR(M0_ERR),
        .M1_REQ(M1_REQ), .M1_WE(M1_WE), .M1_ADDR(M1_ADDR), .M1_DAT(M1_DAT),
        .M1_RDAT(M1_RDAT), .M1_ACK(M1_ACK), .M1_ERR(M1_ERR),
        .W_CYC(W_CYC), .W_STB(W_STB), .W_WE(W_WE), .W_ADDR(W_ADDR),
        .W_DAT_O(W_DAT_O), .W_DAT_I(W_DAT_I), .W_ACK(W_ACK), .GNT(GNT)
    );

    typedef struct {bit g; bit we; logic [31:0] addr; logic [31:0] dat; int len; int gap;} bus_t;
    typedef struct {logic [3:0] fl; logic [31:0] r0; logic [31:0] r1;} rsp_t;
    typedef struct {int lat; logic [31:0] d;} slv_t;

    bus_t        bus_q[$];
    rsp_t        rsp_q[$];
    slv_t        slv_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          m_last;
    logic [31:0] m_rd[2];
    bit          tw[2][3];
    logic [31:0] ta[2][3];
    logic [31:0] td[2][3];

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Model of one granted transfer: what the slave will do, what the bus must show, what the master gets back.
    task automatic push_xfer(input bit g, input bit we, input logic [31:0] a, input logic [31:0] d,
                             input int lat, input int gap, input int len, input bit rsp);
        slv_t s;
        bus_t b;
        rsp_t r;
        s.lat = lat;
        s.d   = $urandom;
        slv_q.push_back(s);
        b.g = g; b.we = we; b.addr = a; b.dat = d; b.gap = gap;
        b.len = (len == -2) ? ((lat < TO) ? lat + 1 : TO) : len;
        bus_q.push_back(b);
        m_last = g;
        if (rsp) begin
            if (lat < TO) begin
                m_rd[g] = s.d;
                r.fl = g ? 4'b0010 : 4'b1000;
            end else begin
                r.fl = g ? 4'b0001 : 4'b0100;
            end
            r.r0 = m_rd[0];
            r.r1 = m_rd[1];
            rsp_q.push_back(r);
        end
    endtask

    task automatic set_m(input bit m, input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
        if (m) begin
            M1_REQ = req; M1_WE = we; M1_ADDR = a; M1_DAT = d;
        end else begin
            M0_REQ = req; M0_WE = we; M0_ADDR = a; M0_DAT = d;
        end
    endtask

    // Each master issues n transfers back to back, holding REQ until its last one is answered.
    task automatic round(input int n0, input int n1, input int lat_first, input bit fast);
        int  n[2], r[2], idx[2], done[2];
        int  lat, cyc;
        bit  g, first;
        n[0] = n0; n[1] = n1;
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 3; k++) begin
                tw[m][k] = 1'($urandom_range(0, 1));
                ta[m][k] = $urandom;
                td[m][k] = $urandom;
            end
            r[m] = n[m]; idx[m] = 0; done[m] = 0;
        end
        first = 1'b1;
        while (r[0] + r[1] > 0) begin
            g   = (r[0] > 0 && r[1] > 0) ? !m_last : (r[1] > 0);
            lat = (first && lat_first >= 0) ? lat_first : (fast ? 0 : int'($urandom_range(0, 5)));
            push_xfer(g, tw[g][idx[g]], ta[g][idx[g]], td[g][idx[g]], lat, first ? -1 : 2, -2, 1'b1);
            idx[g]++;
            r[g]--;
            first = 1'b0;
        end
        @(negedge clk);
        set_m(1'b0, n[0] > 0, tw[0][0], ta[0][0], td[0][0]);
        set_m(1'b1, n[1] > 0, tw[1][0], ta[1][0], td[1][0]);
        cyc = 0;
        while ((done[0] < n[0] || done[1] < n[1]) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (M0_ACK | M0_ERR) begin
                done[0]++;
                if (done[0] < n[0]) set_m(1'b0, 1'b1, tw[0][done[0]], ta[0][done[0]], td[0][done[0]]);
                else M0_REQ = 1'b0;
            end
            if (M1_ACK | M1_ERR) begin
                done[1]++;
                if (done[1] < n[1]) set_m(1'b1, 1'b1, tw[1][done[1]], ta[1][done[1]], td[1][done[1]]);
                else M1_REQ = 1'b0;
            end
            if (!M0_REQ) set_m(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
            if (!M1_REQ) set_m(1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end
        chk("round_complete", done[0] + done[1], n0 + n1);
        M0_REQ = 1'b0;
        M1_REQ = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // M0 requests alone and drops REQ in its second XFER cycle.
    task automatic drop_test(input int lat, input bit rsp);
        bit          we;
        logic [31:0] a, d;
        int          seen, cyc;
        we = 1'($urandom_range(0, 1)); a = $urandom; d = $urandom;
        push_xfer(1'b0, we, a, d, lat, -1, rsp ? -2 : 2, rsp);
        @(negedge clk);
        set_m(1'b0, 1'b1, we, a, d);
        seen = 0; cyc = 0;
        while (seen < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (W_CYC) seen++;
        end
        chk("drop_reached_xfer", seen, 2);
        M0_REQ = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"}, {W_CYC, W_STB, W_WE, GNT, M0_ACK, M0_ERR, M1_ACK, M1_ERR}, 0);
        chk({tag, "_bus"}, {W_ADDR, W_DAT_O}, 0);
        chk({tag, "_rdat"}, {M0_RDAT, M1_RDAT}, 0);
    endtask

    // Slave: acks in the lat-th cycle of W_CYC (never if lat is beyond the timeout window).
    initial begin
        slv_t        s;
        int          k, cl;
        logic [31:0] cd;
        bit          busy;
        busy = 1'b0; k = 0; cl = -1; cd = '0;
        W_ACK = 1'b0;
        W_DAT_I = '0;
        forever begin
            @(negedge clk);
            if (W_CYC) begin
                if (!busy) begin
                    busy = 1'b1;
                    k = 0;
                    if (slv_q.size() > 0) begin
                        s = slv_q.pop_front();
                        cl = s.lat;
                        cd = s.d;
                    end else begin
                        cl = -1;
                        cd = '0;
                    end
                end
                W_ACK = (k == cl);
                W_DAT_I = W_ACK ? cd : $urandom;
                k++;
            end else begin
                busy = 1'b0;
                W_ACK = 1'b0;
            end
        end
    end

    // Bus monitor: checks each slave cycle's owner, contents, hold, length and spacing.
    initial begin
        bus_t cur;
        bit   prev, have;
        int   hi, lo;
        prev = 1'b0; have = 1'b0; hi = 0; lo = 0;
        forever begin
            @(negedge clk);
            if (W_CYC && !prev) begin
                if (bus_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    have = 1'b0;
                    $display("FAIL bus_unexpected: got cycle to %0h, expected none", W_ADDR);
                end else begin
                    cur = bus_q.pop_front();
                    have = 1'b1;
                    chk("bus_gnt", GNT, cur.g);
                    chk("bus_we", W_WE, cur.we);
                    chk("bus_addr", W_ADDR, cur.addr);
                    chk("bus_dat", W_DAT_O, cur.dat);
                    if (cur.gap >= 0) chk("bus_gap", lo, cur.gap);
                end
                hi = 1;
            end else if (W_CYC) begin
                hi++;
                if (have) chk("bus_hold", {W_WE, W_ADDR, W_DAT_O}, {cur.we, cur.addr, cur.dat});
            end else if (prev) begin
                if (have && cur.len >= 0) chk("bus_len", hi, cur.len);
                lo = 1;
            end else begin
                lo++;
            end
            if (W_CYC) chk("stb_eq_cyc", W_STB, W_CYC);
            prev = W_CYC;
        end
    end

    // Response monitor: every ACK/ERR pulse must match the next expected master response.
    initial begin
        rsp_t       e;
        logic [3:0] fl;
        forever begin
            @(negedge clk);
            fl = {M0_ACK, M0_ERR, M1_ACK, M1_ERR};
            if (fl != 0) begin
                if (rsp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rsp_unexpected: got flags %b, expected none", fl);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp_flags", fl, e.fl);
                    chk("rsp_rdat0", M0_RDAT, e.r0);
                    chk("rsp_rdat1", M1_RDAT, e.r1);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          seen, cyc, a0, a1;
        logic [31:0] a;
        m_last = 1'b1;
        m_rd[0] = '0;
        m_rd[1] = '0;
        W_RST = 1'b0;
        set_m(1'b0, 1'b0, 1'b0, '0, '0);
        set_m(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        chk_reset("reset_init");
        W_RST = 1'b1;
        repeat (2) @(negedge clk);

        round(1, 0, 1, 1'b0);
        round(0, 1, -1, 1'b0);
        round(3, 3, 0, 1'b1);
        drop_test(1, 1'b1);
        drop_test(99, 1'b0);

        // Asynchronous reset in the middle of an M0 transfer.
        a = $urandom;
        push_xfer(1'b0, 1'b0, a, '0, 99, -1, -1, 1'b0);
        @(negedge clk);
        set_m(1'b0, 1'b1, 1'b0, a, '0);
        seen = 0; cyc = 0;
        while (seen < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (W_CYC) seen++;
        end
        chk("rst_reached_xfer", seen, 2);
        #2 W_RST = 1'b0;
        M0_REQ = 1'b0;
        #1 chk_reset("reset_mid");
        m_last = 1'b1;
        m_rd[0] = '0;
        m_rd[1] = '0;
        repeat (2) @(negedge clk);
        W_RST = 1'b1;
        repeat (2) @(negedge clk);

        round(1, 1, TO + 3, 1'b0);
        for (int i = 0; i < 30; i++) begin
            a0 = $urandom_range(0, 2);
            a1 = $urandom_range(0, 2);
            if (a0 + a1 == 0) a0 = 1;
            round(a0, a1, -1, 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("bus_queue_drained", bus_q.size(), 0);
        chk("rsp_queue_drained", rsp_q.size(), 0);
        chk("slv_queue_drained", slv_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
